// File: rtl/myproject_acc_31s_16_rnd.sv
// Accumulate-and-requantise stage: sums a last-terminated group of signed products plus bias,
// then rounds, shifts and saturates into a registered valid/ready slot. Define MYPROJECT_ACC_RELU_EN for a ReLU output clamp.
module myproject_acc_31s_16_rnd #(
  parameter int DIN_WIDTH  = 31,
  parameter int ACC_WIDTH  = 40,
  parameter int BIAS_WIDTH = 16,
  parameter int DOUT_WIDTH = 16,
  parameter int FRAC_SHIFT = 10,
  parameter int CNT_WIDTH  = 10
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         ce,
  input  logic signed [BIAS_WIDTH-1:0] bias,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DIN_WIDTH-1:0]  in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DOUT_WIDTH-1:0] out_data,
  output logic                         out_sat,
  output logic [CNT_WIDTH-1:0]         out_terms
);

  typedef enum logic {S_IDLE, S_ACC} state_t;

  localparam logic signed [ACC_WIDTH:0] RND_HALF = (ACC_WIDTH+1)'(1) <<< (FRAC_SHIFT-1);
  localparam logic signed [ACC_WIDTH:0] OUT_MAX  =
    {{(ACC_WIDTH-DOUT_WIDTH+2){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] OUT_MIN  = ~OUT_MAX;

  // One guard bit keeps the rounding increment from wrapping near full scale.
  function automatic logic signed [ACC_WIDTH:0] round_shift(input logic signed [ACC_WIDTH-1:0] s);
    logic signed [ACC_WIDTH:0] t;
    t = {s[ACC_WIDTH-1], s} + RND_HALF;
    return t >>> FRAC_SHIFT;
  endfunction

  // Returns {clipped, value}.
  function automatic logic [DOUT_WIDTH:0] sat_clip(input logic signed [ACC_WIDTH:0] r);
    if (r > OUT_MAX)      return {1'b1, OUT_MAX[DOUT_WIDTH-1:0]};
    else if (r < OUT_MIN) return {1'b1, OUT_MIN[DOUT_WIDTH-1:0]};
    else                  return {1'b0, r[DOUT_WIDTH-1:0]};
  endfunction

  state_t                         r_state;
  logic signed [ACC_WIDTH-1:0]    r_acc;
  logic [CNT_WIDTH-1:0]           r_cnt;
  logic                           r_out_valid;
  logic signed [DOUT_WIDTH-1:0]   r_out_data;
  logic                           r_out_sat;
  logic [CNT_WIDTH-1:0]           r_out_terms;

  logic                           w_accept;
  logic signed [ACC_WIDTH-1:0]    w_din;
  logic signed [ACC_WIDTH-1:0]    w_base;
  logic signed [ACC_WIDTH-1:0]    w_sum;
  logic [CNT_WIDTH-1:0]           w_cnt_nxt;
  logic [DOUT_WIDTH:0]            w_clip;
  logic signed [DOUT_WIDTH-1:0]   w_res;
  logic                           w_sat;

  assign in_ready  = reset_n && ce && !(r_out_valid && !out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_din     = {{(ACC_WIDTH-DIN_WIDTH){in_data[DIN_WIDTH-1]}}, in_data};

  always_comb begin
    w_base    = r_acc;
    w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + CNT_WIDTH'(1);
    if (r_state == S_IDLE) begin
      w_base    = {{(ACC_WIDTH-BIAS_WIDTH-FRAC_SHIFT){bias[BIAS_WIDTH-1]}}, bias, {FRAC_SHIFT{1'b0}}};
      w_cnt_nxt = CNT_WIDTH'(1);
    end
    w_sum  = w_base + w_din;
    w_clip = sat_clip(round_shift(w_sum));
    w_sat  = w_clip[DOUT_WIDTH];
`ifdef MYPROJECT_ACC_RELU_EN
    w_res  = w_clip[DOUT_WIDTH-1] ? '0 : w_clip[DOUT_WIDTH-1:0];
`else
    w_res  = w_clip[DOUT_WIDTH-1:0];
`endif
  end

  // Accumulate stage / result slot boundary
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
      r_out_terms <= '0;
    end else if (ce) begin
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      if (w_accept) begin
        r_acc <= w_sum;
        r_cnt <= w_cnt_nxt;
        if (in_last) begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b1;
          r_out_data  <= w_res;
          r_out_sat   <= w_sat;
          r_out_terms <= w_cnt_nxt;
        end else begin
          r_state <= S_ACC;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign out_terms = r_out_terms;

endmodule
